// File: rtl/ols_pkg.sv
// rtl/ols_pkg.sv - shared definitions for the overlap-save frame chain
// Purpose: clog2 helper, FSM state encoding and default frame geometry,
//          shared by ols_frame_sched, ols_sample_buf and discard_half.
// Ports:   none (package).
package ols_pkg;

  // Number of bits needed to index 'value' entries.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_EMIT = 1'b1
  } ols_state_t;

  localparam int NFFT_DEF    = 32;
  localparam int DISCARD_DEF = 16;
  // New samples gathered per steady-state frame.
  localparam int NEW_LEN     = NFFT_DEF - DISCARD_DEF;

endpackage

// File: rtl/ols_sample_buf.sv
// rtl/ols_sample_buf.sv - NFFT-entry circular sample store for the scheduler
// Purpose: NFFT x 2W register file, one synchronous write port, one
//          asynchronous read port. With OLS_ZERO_PRIME_EN defined the whole
//          array is cleared on i_rst so the first frame's overlap reads as 0.
// Ports:   i_clk    clock
//          i_rst    synchronous active-high clear (only with OLS_ZERO_PRIME_EN)
//          i_we     write enable
//          i_waddr  write address
//          i_wdata  {re, im} sample to store
//          i_raddr  read address
//          o_rdata  {re, im} sample at i_raddr (combinational)
module ols_sample_buf import ols_pkg::*; #(
  parameter int W    = 16,
  parameter int NFFT = NFFT_DEF
) (
  input  logic                     i_clk,
`ifdef OLS_ZERO_PRIME_EN
  input  logic                     i_rst,
`endif
  input  logic                     i_we,
  input  logic [clog2(NFFT)-1:0]   i_waddr,
  input  logic [2*W-1:0]           i_wdata,
  input  logic [clog2(NFFT)-1:0]   i_raddr,
  output logic [2*W-1:0]           o_rdata
);

  logic [2*W-1:0] r_mem [NFFT];

  always_ff @(posedge i_clk) begin
`ifdef OLS_ZERO_PRIME_EN
    if (i_rst) begin
      for (int i = 0; i < NFFT; i++) r_mem[i] <= '0;
    end else
`endif
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ols_frame_sched.sv
// rtl/ols_frame_sched.sv - overlap-save frame scheduler feeding the FFT
// Purpose: collects a complex sample stream into NFFT-sample frames made of
//          DISCARD carried samples plus NFFT-DISCARD new ones, and streams
//          each frame out with first/last/index framing.
// Config:  OLS_ZERO_PRIME_EN - buffer cleared on reset; first frame leaves
//          after NFFT-DISCARD accepts with zero overlap. Undefined: first
//          frame waits for NFFT accepts.
// Ports:   i_clk, i_rst         clock, synchronous active-high reset
//          i_valid, i_x_re/im   input sample stream
//          o_in_ready           sample accepted when i_valid && o_in_ready
//          o_valid, i_ready     output handshake
//          o_y_re/im            output sample
//          o_first, o_last      beat 0 / beat NFFT-1 markers
//          o_idx                beat index within frame
//          o_busy               frame emission in progress
module ols_frame_sched import ols_pkg::*; #(
  parameter int W       = 16,
  parameter int NFFT    = NFFT_DEF,
  parameter int DISCARD = NFFT_DEF - NEW_LEN
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic [W-1:0]           i_x_re,
  input  logic [W-1:0]           i_x_im,
  output logic                   o_in_ready,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [W-1:0]           o_y_re,
  output logic [W-1:0]           o_y_im,
  output logic                   o_first,
  output logic                   o_last,
  output logic [clog2(NFFT)-1:0] o_idx,
  output logic                   o_busy
);

  localparam int AW = clog2(NFFT);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] ONE_A     = AW'(1);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [CW-1:0] NEW_CNT   = CW'(NFFT - DISCARD);
  localparam logic [CW-1:0] FULL_CNT  = CW'(NFFT);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NFFT - 1);

  ols_state_t     r_state, w_state_nxt;
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_new_cnt, r_beat;
  logic           r_valid, r_first, r_last;
  logic [AW-1:0]  r_idx;
  logic [W-1:0]   r_y_re, r_y_im;

  logic           w_in_ready, w_busy;
  logic           w_accept, w_fill_done, w_load, w_xfer, w_xfer_last;
  logic [CW-1:0]  w_target;
  logic [AW-1:0]  w_raddr;
  logic [2*W-1:0] w_rdata;

`ifdef OLS_ZERO_PRIME_EN
  assign w_target = NEW_CNT;
`else
  // Without a cleared buffer the first frame must wait for a full window.
  logic r_primed;
  assign w_target = r_primed ? NEW_CNT : FULL_CNT;
`endif

  assign w_accept    = i_valid && w_in_ready;
  assign w_fill_done = w_accept && ((r_new_cnt + ONE_C) == w_target);
  assign w_xfer      = r_valid && i_ready;
  assign w_xfer_last = w_xfer && r_last;
  // Fetch the next beat whenever the output register is empty or draining.
  assign w_load      = (r_state == ST_EMIT) && (r_beat != FULL_CNT) && (!r_valid || i_ready);
  assign w_raddr     = r_rd_ptr + r_beat[AW-1:0];

  ols_sample_buf #(.W(W), .NFFT(NFFT)) u_buf (
    .i_clk   (i_clk),
`ifdef OLS_ZERO_PRIME_EN
    .i_rst   (i_rst),
`endif
    .i_we    (w_accept),
    .i_waddr (r_wr_ptr),
    .i_wdata ({i_x_re, i_x_im}),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_FILL;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_in_ready = 1'b1;
        if (w_fill_done) w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        w_busy = 1'b1;
        if (w_xfer_last) w_state_nxt = ST_FILL;
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_new_cnt <= '0;
      r_beat    <= '0;
      r_valid   <= 1'b0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_idx     <= '0;
      r_y_re    <= '0;
      r_y_im    <= '0;
`ifndef OLS_ZERO_PRIME_EN
      r_primed  <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_wr_ptr  <= r_wr_ptr + ONE_A;
        r_new_cnt <= r_new_cnt + ONE_C;
      end
      // Oldest sample of the window is the slot just past the final write.
      if (w_fill_done) begin
        r_rd_ptr <= r_wr_ptr + ONE_A;
        r_beat   <= '0;
      end
      if (w_load) begin
        r_valid <= 1'b1;
        r_y_re  <= w_rdata[2*W-1:W];
        r_y_im  <= w_rdata[W-1:0];
        r_idx   <= r_beat[AW-1:0];
        r_first <= (r_beat == '0);
        r_last  <= (r_beat == LAST_BEAT);
        r_beat  <= r_beat + ONE_C;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      if (w_xfer_last) begin
        r_new_cnt <= '0;
`ifndef OLS_ZERO_PRIME_EN
        r_primed  <= 1'b1;
`endif
      end
    end
  end

  assign o_in_ready = w_in_ready;
  assign o_busy     = w_busy;
  assign o_valid    = r_valid;
  assign o_y_re     = r_y_re;
  assign o_y_im     = r_y_im;
  assign o_first    = r_first;
  assign o_last     = r_last;
  assign o_idx      = r_idx;

endmodule

// File: tb/tb_ols_frame_sched.sv
// tb/tb_ols_frame_sched.sv - scoreboard bench for ols_frame_sched
module tb_ols_frame_sched;

  localparam int W       = 16;
  localparam int NFFT    = 32;
  localparam int DISCARD = 16;
  localparam int NEW     = NFFT - DISCARD;
`ifdef OLS_ZERO_PRIME_EN
  localparam bit PRIME = 1'b1;
`else
  localparam bit PRIME = 1'b0;
`endif
  // Frame that carries samples 0..31: second frame when zero-primed.
  localparam int TF = PRIME ? 1 : 0;
  localparam logic [W-1:0] JUNK = 16'h7AAA;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] x_re = '0, x_im = '0;
  logic         in_ready, out_valid, y_first, y_last, busy;
  logic [W-1:0] y_re, y_im;
  logic [4:0]   y_idx;

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [4:0]   idx;
    logic         first;
    logic         last;
  } beat_t;

  beat_t exp_q[$];
  beat_t cur, held, expb;
  bit    hold_pending = 0;
  int    errors = 0;
  int    checks = 0;
  int    frames_seen = 0;
  int    n = 0;

  always #5 clk = ~clk;

  ols_frame_sched #(.W(W), .NFFT(NFFT), .DISCARD(DISCARD)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (in_valid),
    .i_x_re     (x_re),
    .i_x_im     (x_im),
    .o_in_ready (in_ready),
    .o_valid    (out_valid),
    .i_ready    (out_ready),
    .o_y_re     (y_re),
    .o_y_im     (y_im),
    .o_first    (y_first),
    .o_last     (y_last),
    .o_idx      (y_idx),
    .o_busy     (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected frames after 'total' accepts of samples 0,1,2...: each frame is
  // the last NFFT accepted samples, with zeros standing in before sample 0.
  task automatic push_frames(input int total);
    int fin;
    fin = PRIME ? NEW : NFFT;
    while (fin <= total) begin
      for (int k = 0; k < NFFT; k++) begin
        int    v;
        beat_t b;
        v = fin - NFFT + k;
        if (v < 0) v = 0;
        b.re    = W'(v);
        b.im    = W'(-v);
        b.idx   = 5'(k);
        b.first = (k == 0);
        b.last  = (k == NFFT - 1);
        exp_q.push_back(b);
      end
      fin += NEW;
    end
  endtask

  // Scoreboard monitor: sampled at negedge, transfer happens at next posedge.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 0;
      frames_seen  = 0;
    end else begin
      if (busy) check("in_ready_in_emit", in_ready, 0);
      if (out_valid) begin
        cur = {y_re, y_im, y_idx, y_first, y_last};
        if (hold_pending) check("stall_hold", cur, held);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h expected none", cur);
          end else begin
            expb = exp_q.pop_front();
            check("beat", cur, expb);
          end
          if (y_last) frames_seen++;
          hold_pending = 0;
        end else begin
          held = cur;
          hold_pending = 1;
        end
      end else if (hold_pending) begin
        check("valid_dropped", 0, 1);
        hold_pending = 0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    exp_q.delete();
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_first_last", {y_first, y_last}, 0);
    check("rst_idx_data", {y_idx, y_re, y_im}, 0);
  endtask

  // Offers a sample every cycle (or every other cycle when gapped); while the
  // scheduler is not ready a junk value is offered and must be dropped.
  task automatic feed(input int total, input bit gap);
    int acc = 0;
    int cyc = 0;
    bit tog = 0;
    while (acc < total && cyc < 5000) begin
      tog = ~tog;
      if (!gap || tog) begin
        in_valid = 1'b1;
        if (in_ready) begin
          x_re = W'(n);
          x_im = W'(-n);
          n++;
          acc++;
        end else begin
          x_re = JUNK;
          x_im = JUNK;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("feed_accepts", acc, total);
  endtask

  task automatic drain(input string name);
    int c = 0;
    while ((exp_q.size() != 0 || out_valid || busy) && c < 2000) begin
      @(posedge clk);
      #1;
      c++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic wait_beat(input int tf, input int idx, input string name);
    int c = 0;
    while (!(frames_seen == tf && out_valid && y_idx == 5'(idx)) && c < 3000) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(name, (c < 3000), 1);
  endtask

  task automatic stall_at(input int tf, input int idx);
    wait_beat(tf, idx, "bp_found");
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check("bp_valid", out_valid, 1);
      check("bp_idx", y_idx, idx);
      check("bp_re", y_re, idx);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
  endtask

  initial begin
    // Steady state, continuous input.
    do_reset();
    push_frames(64);
    feed(64, 1'b0);
    drain("steady");

    // Gapped input gives identical frames.
    do_reset();
    push_frames(64);
    feed(64, 1'b1);
    drain("gapped");

    // Backpressure at idx 5 of the 0..31 frame.
    do_reset();
    push_frames(48);
    fork
      feed(48, 1'b0);
      stall_at(TF, 5);
    join
    drain("backpressure");

    // Reset while emitting idx 10 of the 0..31 frame.
    do_reset();
    push_frames(32);
    feed(32, 1'b0);
    wait_beat(TF, 10, "rst_mid_found");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    n = 0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    push_frames(PRIME ? NEW : NFFT);
    feed(PRIME ? NEW : NFFT, 1'b0);
    drain("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
